urv_timer_irq: RTL and testbench

- Interrupt source stage feeding the core's exception unit.
- Produces the timer tick strobe (exp_tick) and the external interrupt strobe (exp_irq) that the exception unit masks with mie/mstatus.ie.
- Contains a prescaled 32-bit timer with compare, one-shot and auto-reload modes, plus a synchroniser and edge detector for the asynchronous external IRQ line.
- Configured through a small single-cycle register port driven by the core's peripheral decode.

---
 rtl/urv_timer_irq_if.sv | 21 ++
 rtl/urv_timer_irq.sv | 147 ++++++++++++++
 tb/tb_urv_timer_irq.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/urv_timer_irq_if.sv
// Register port between the core's peripheral decode and urv_timer_irq.
interface urv_timer_irq_if;
  logic        reg_we_i;
  logic [1:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;

  modport master (
    output reg_we_i,
    output reg_addr_i,
    output reg_wdata_i,
    input  reg_rdata_o
  );

  modport slave (
    input  reg_we_i,
    input  reg_addr_i,
    input  reg_wdata_i,
    output reg_rdata_o
  );
endinterface

// File: rtl/urv_timer_irq.sv
// Interrupt source stage: prescaled 32-bit compare timer (one-shot or
// auto-reload) driving tick_o, and a synchronised external IRQ driving irq_o.
module urv_timer_irq #(
  parameter int unsigned PRESCALE_WIDTH = 16,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  urv_timer_irq_if.slave  reg_if,
  input  logic            irq_ext_i,
  output logic            tick_o,
  output logic            irq_o
);

  typedef enum logic [1:0] {
    REG_CTRL     = 2'd0,
    REG_PRESCALE = 2'd1,
    REG_COMPARE  = 2'd2,
    REG_COUNT    = 2'd3
  } reg_sel_e;

  localparam logic [PRESCALE_WIDTH-1:0] PCNT_ONE = PRESCALE_WIDTH'(1);

  logic                      en_q, en_d;
  logic                      reload_q, reload_d;
  logic                      edge_q, edge_d;
  logic                      pend_q, pend_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [31:0]               compare_q, compare_d;
  logic [31:0]               count_q, count_d;
  logic                      tick_q, tick_d;
  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      irq_d_q;
  logic                      irq_q, irq_d;

  reg_sel_e sel;
  logic     ctrl_wr, presc_wr, cmp_wr, cnt_wr;
  logic     pcnt_run, strobe, match, tmr_upd, pend_set;
  logic     irq_s;

  assign sel      = reg_sel_e'(reg_if.reg_addr_i);
  assign ctrl_wr  = reg_if.reg_we_i && (sel == REG_CTRL);
  assign presc_wr = reg_if.reg_we_i && (sel == REG_PRESCALE);
  assign cmp_wr   = reg_if.reg_we_i && (sel == REG_COMPARE);
  assign cnt_wr   = reg_if.reg_we_i && (sel == REG_COUNT);

  // A CTRL write clearing EN freezes the prescaler in that same cycle.
  assign pcnt_run = en_q && !(ctrl_wr && !reg_if.reg_wdata_i[0]);
  assign strobe   = pcnt_run && (pcnt_q == presc_q) && !presc_wr;
  assign match    = strobe && (count_q == compare_q);
  // Register writes override the strobe's COUNT/EN update and its tick;
  // only a CTRL write still lets the match set PEND (set beats clear).
  assign tmr_upd  = strobe && !(ctrl_wr || cmp_wr || cnt_wr);
  assign pend_set = match && !(cmp_wr || cnt_wr);

  assign irq_s    = sync_q[SYNC_STAGES-1];

  // Next-state for configuration, prescaler, timer and output registers.
  always_comb begin
    en_d      = en_q;
    reload_d  = reload_q;
    edge_d    = edge_q;
    pend_d    = pend_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;
    compare_d = compare_q;
    count_d   = count_q;
    tick_d    = tmr_upd && match;
    irq_d     = edge_q ? (irq_s && !irq_d_q) : irq_s;

    if (presc_wr) begin
      presc_d = reg_if.reg_wdata_i[PRESCALE_WIDTH-1:0];
      pcnt_d  = '0;
    end else if (pcnt_run) begin
      pcnt_d = (pcnt_q == presc_q) ? '0 : pcnt_q + PCNT_ONE;
    end

    if (tmr_upd) begin
      if (!match) begin
        count_d = count_q + 32'd1;
      end else if (reload_q) begin
        count_d = '0;
      end else begin
        en_d = 1'b0;
      end
    end

    if (ctrl_wr) begin
      en_d     = reg_if.reg_wdata_i[0];
      reload_d = reg_if.reg_wdata_i[1];
      edge_d   = reg_if.reg_wdata_i[2];
      if (reg_if.reg_wdata_i[8]) pend_d = 1'b0;
    end
    if (pend_set) pend_d = 1'b1;

    if (cmp_wr) compare_d = reg_if.reg_wdata_i;
    if (cnt_wr) count_d   = reg_if.reg_wdata_i;
  end

  // State registers, all cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q      <= 1'b0;
      reload_q  <= 1'b0;
      edge_q    <= 1'b0;
      pend_q    <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      compare_q <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      sync_q    <= '0;
      irq_d_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      reload_q  <= reload_d;
      edge_q    <= edge_d;
      pend_q    <= pend_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      compare_q <= compare_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_ext_i};
      irq_d_q   <= irq_s;
      irq_q     <= irq_d;
    end
  end

  // Combinational read mux; reads have no side effects.
  always_comb begin
    reg_if.reg_rdata_o = '0;
    unique case (sel)
      REG_CTRL:     reg_if.reg_rdata_o = {23'd0, pend_q, 5'd0, edge_q, reload_q, en_q};
      REG_PRESCALE: reg_if.reg_rdata_o = 32'(presc_q);
      REG_COMPARE:  reg_if.reg_rdata_o = compare_q;
      REG_COUNT:    reg_if.reg_rdata_o = count_q;
      default:      reg_if.reg_rdata_o = '0;
    endcase
  end

  assign tick_o = tick_q;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_urv_timer_irq.sv
// Scoreboard bench for urv_timer_irq: a behavioural model predicts read data,
// tick_o and irq_o for every cycle; a negedge monitor compares against the DUT.
module tb_urv_timer_irq;
  localparam int unsigned PW   = 16;
  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic rst_n_i = 1'b0;
  logic irq_ext = 1'b0;
  logic irq_lvl = 1'b0;
  logic tick, irq;

  urv_timer_irq_if bus ();

  urv_timer_irq #(.PRESCALE_WIDTH(PW), .SYNC_STAGES(SYNC)) u_dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n_i),
    .reg_if   (bus),
    .irq_ext_i(irq_ext),
    .tick_o   (tick),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] rdata;
    logic        tick;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic          m_en, m_reload, m_edge, m_pend;
  logic [PW-1:0] m_presc, m_pcnt;
  logic [31:0]   m_cmp, m_cnt;
  logic          m_tick, m_irq;
  logic          hist [0:SYNC];   // hist[k] = irq_ext sampled k+1 edges ago

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return (m_pend ? 32'h100 : 32'h0) | (m_edge ? 32'h4 : 32'h0) |
                      (m_reload ? 32'h2 : 32'h0) | (m_en ? 32'h1 : 32'h0);
      2'd1:    return {16'd0, m_presc};
      2'd2:    return m_cmp;
      default: return m_cnt;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_reload = 0; m_edge = 0; m_pend = 0;
    m_presc = 0; m_pcnt = 0; m_cmp = 0; m_cnt = 0;
    m_tick = 0; m_irq = 0;
    for (int i = 0; i <= SYNC; i++) hist[i] = 1'b0;
  endtask

  // One clock edge of the behavioural model, from the inputs seen at that edge.
  task automatic model_edge(input logic we, input logic [1:0] a,
                            input logic [31:0] wd, input logic irq_in);
    logic wr_ctrl, wr_presc, wr_val, running, fire, hit, keep;
    wr_ctrl  = we && a == 2'd0;
    wr_presc = we && a == 2'd1;
    wr_val   = we && (a == 2'd2 || a == 2'd3);
    running  = m_en && !(wr_ctrl && !wd[0]);
    fire     = running && (m_pcnt == m_presc) && !wr_presc;
    hit      = fire && (m_cnt == m_cmp);
    keep     = fire && !wr_ctrl && !wr_val;   // strobe effect not overridden

    // external irq: level or rising-edge of the synchronised signal
    m_irq = m_edge ? (hist[SYNC-1] && !hist[SYNC]) : hist[SYNC-1];
    for (int i = SYNC; i >= 1; i--) hist[i] = hist[i-1];
    hist[0] = irq_in;

    m_tick = keep && hit;

    if (wr_presc)     m_pcnt = 0;
    else if (running) m_pcnt = fire ? PW'(0) : m_pcnt + PW'(1);
    if (wr_presc) m_presc = wd[PW-1:0];

    if (keep) begin
      if (!hit)          m_cnt = m_cnt + 1;
      else if (m_reload) m_cnt = 0;
      else               m_en = 0;
    end
    if (we && a == 2'd3) m_cnt = wd;
    if (we && a == 2'd2) m_cmp = wd;
    if (wr_ctrl) begin
      m_en = wd[0]; m_reload = wd[1]; m_edge = wd[2];
      if (wd[8]) m_pend = 0;
    end
    if (hit && !wr_val) m_pend = 1;
  endtask

  task automatic push_exp();
    exp_t e;
    e.addr  = bus.reg_addr_i;
    e.rdata = m_read(bus.reg_addr_i);
    e.tick  = m_tick;
    e.irq   = m_irq;
    sb.push_back(e);
  endtask

  task automatic drive(input logic we, input logic [1:0] a, input logic [31:0] wd);
    bus.reg_we_i    = we;
    bus.reg_addr_i  = a;
    bus.reg_wdata_i = wd;
    irq_ext         = irq_lvl;
  endtask

  task automatic cycle(input logic we, input logic [1:0] a, input logic [31:0] wd);
    @(posedge clk);
    if (rst_n_i) model_edge(bus.reg_we_i, bus.reg_addr_i, bus.reg_wdata_i, irq_ext);
    #1;
    drive(we, a, wd);
    push_exp();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cycle(1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    cycle(1'b0, a, 32'd0);
  endtask

  // Reset asserted between edges; expectation pushed after the model is cleared.
  task automatic async_reset_mid();
    @(posedge clk);
    if (rst_n_i) model_edge(bus.reg_we_i, bus.reg_addr_i, bus.reg_wdata_i, irq_ext);
    #1;
    drive(1'b0, 2'd3, 32'd0);
    #2;
    rst_n_i = 1'b0;
    model_reset();
    push_exp();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    drive(1'b0, 2'd0, 32'd0);
    #2;
    rst_n_i = 1'b1;
    push_exp();
  endtask

  // Monitor: compare every predicted cycle away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.reg_rdata_o !== e.rdata) begin
          errors++;
          $display("FAIL rdata addr=%0d got=%h exp=%h t=%0t", e.addr, bus.reg_rdata_o, e.rdata, $time);
        end
        checks++;
        if (tick !== e.tick) begin
          errors++;
          $display("FAIL tick_o got=%b exp=%b t=%0t", tick, e.tick, $time);
        end
        checks++;
        if (irq !== e.irq) begin
          errors++;
          $display("FAIL irq_o got=%b exp=%b t=%0t", irq, e.irq, $time);
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  a;
    model_reset();
    drive(1'b0, 2'd0, 32'd0);

    // reset state, every register
    for (int i = 0; i < 4; i++) rd(2'(i));
    release_reset();
    for (int i = 0; i < 4; i++) rd(2'(i));

    // periodic tick
    wr(2'd1, 32'd3); wr(2'd2, 32'd2); wr(2'd3, 32'd0); wr(2'd0, 32'h3);
    repeat (30) rd(2'd3);
    rd(2'd0);

    // one-shot
    wr(2'd0, 32'h100); wr(2'd1, 32'd0); wr(2'd2, 32'd5); wr(2'd3, 32'd0);
    wr(2'd0, 32'h1);
    repeat (10) rd(2'd3);
    rd(2'd0);

    // COUNT write colliding with a match
    wr(2'd0, 32'h100); wr(2'd2, 32'd3); wr(2'd3, 32'd0); wr(2'd0, 32'h3);
    rd(2'd3); rd(2'd3); rd(2'd3);
    wr(2'd3, 32'h10);
    repeat (4) rd(2'd3);

    // CTRL write with PEND clear colliding with a match
    wr(2'd0, 32'h100); wr(2'd3, 32'd0); wr(2'd0, 32'h3);
    rd(2'd3); rd(2'd3); rd(2'd3);
    wr(2'd0, 32'h103);
    rd(2'd0); rd(2'd0);

    // wrap through 0xFFFFFFFF
    wr(2'd0, 32'h100); wr(2'd1, 32'd0); wr(2'd2, 32'd3);
    wr(2'd3, 32'hFFFF_FFFE); wr(2'd0, 32'h1);
    repeat (8) rd(2'd3);

    // external IRQ, edge then level
    wr(2'd0, 32'h104);
    irq_lvl = 1'b1; repeat (20) rd(2'd0);
    irq_lvl = 1'b0; repeat (6) rd(2'd0);
    wr(2'd0, 32'h0);
    irq_lvl = 1'b1; repeat (20) rd(2'd2);
    irq_lvl = 1'b0; repeat (6) rd(2'd2);

    // async reset mid-count
    wr(2'd1, 32'd1); wr(2'd2, 32'd7); wr(2'd3, 32'd0); wr(2'd0, 32'h3);
    irq_lvl = 1'b1; repeat (9) rd(2'd3);
    async_reset_mid();
    irq_lvl = 1'b0;
    for (int i = 0; i < 4; i++) rd(2'(i));
    release_reset();
    for (int k = 0; k < 2; k++) for (int i = 0; i < 4; i++) rd(2'(i));

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) irq_lvl = ~irq_lvl;
      a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) < 3) begin
        case (a)
          2'd0: begin
            d = $urandom;
            if ($urandom_range(0, 3) != 0) d = d & 32'h107;
            if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
          end
          2'd1: d = $urandom_range(0, 3);
          2'd2: d = $urandom_range(0, 12);
          default: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                   : $urandom_range(0, 12);
        endcase
        wr(a, d);
      end else begin
        rd(a);
      end
    end

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
